// File: rtl/ccsds123_pkg.sv
// Shared constants and elaboration-time helpers for the CCSDS 123 entropy coders.
package ccsds123_pkg;

    localparam int CW_LEN_W = 6;
    localparam int UMAX_MIN = 8;
    localparam int UMAX_MAX = 32;

    function automatic int acc_width(input int d, input int gamma_star);
        return d + gamma_star + 1;
    endfunction

    // Accumulator seed written for every band at the first pixel of an image.
    function automatic longint acc_init(input int kzp, input int gamma0);
        return ((3 * (longint'(1) << (kzp + 6)) - 49) * (longint'(1) << gamma0)) >> 7;
    endfunction

endpackage

// File: rtl/ccsds123_k_select.sv
// Golomb-Power-of-2 parameter search: largest k in 0..D-2 with G*2^k <= A + floor(49*G/128).
// Purely combinational; no latency, no flow control.
module ccsds123_k_select
    import ccsds123_pkg::*;
#(
    parameter int D          = 16,
    parameter int GAMMA_STAR = 6,
    parameter int ACC_W      = acc_width(D, GAMMA_STAR),
    parameter int KW         = $clog2(D)
) (
    input  logic [ACC_W-1:0]      i_acc,
    input  logic [GAMMA_STAR-1:0] i_cnt,
    output logic [KW-1:0]         o_k
);

    localparam int CW = ACC_W + 2;

    logic [CW-1:0] w_rhs;
    logic          w_found;

    assign w_rhs = CW'(i_acc) + ((CW'(i_cnt) * CW'(49)) >> 7);

    // Highest k wins; falls through to k=0 when nothing satisfies the bound.
    always_comb begin
        o_k     = '0;
        w_found = 1'b0;
        for (int k = D - 2; k >= 0; k--) begin
            if (!w_found && ((CW'(i_cnt) << k) <= w_rhs)) begin
                o_k     = KW'(k);
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ccsds123_sa_encoder.sv
// Sample-adaptive GPO2 coder: one right-aligned codeword per mapped residual, BIP order.
// Latency 2 cycles, one residual per cycle, no backpressure (input is always accepted).
module ccsds123_sa_encoder
    import ccsds123_pkg::*;
#(
    parameter int D          = 16,
    parameter int NX         = 4,
    parameter int NY         = 4,
    parameter int NZ         = 16,
    parameter int UMAX       = 18,
    parameter int GAMMA0     = 1,
    parameter int GAMMA_STAR = 6,
    parameter int KZP        = 8
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic [D-1:0]        res,
    input  logic                res_valid,
    output logic [UMAX+D-1:0]   cw_data,
    output logic [CW_LEN_W-1:0] cw_len,
    output logic                cw_valid,
    output logic                cw_last
);

    localparam int ACC_W    = acc_width(D, GAMMA_STAR);
    localparam int KW       = $clog2(D);
    localparam int DW       = UMAX + D;
    localparam int NPIX     = NX * NY;
    localparam int ZW       = (NZ > 1) ? $clog2(NZ) : 1;
    localparam int TW       = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int UMAX_EFF = (UMAX < UMAX_MIN) ? UMAX_MIN : ((UMAX > UMAX_MAX) ? UMAX_MAX : UMAX);
    localparam logic [GAMMA_STAR-1:0] G_INIT   = GAMMA_STAR'(1 << GAMMA0);
    localparam logic [GAMMA_STAR-1:0] G_MAX    = GAMMA_STAR'((1 << GAMMA_STAR) - 1);
    localparam logic [ACC_W-1:0]      ACC_INIT = ACC_W'(acc_init(KZP, GAMMA0));

    logic [ZW-1:0]         r_z;
    logic [TW-1:0]         r_t;
    logic [GAMMA_STAR-1:0] r_g;
    logic [ACC_W-1:0]      r_acc [NZ];

    logic                  r_s1_vld;
    logic                  r_s1_first;
    logic                  r_s1_last;
    logic [KW-1:0]         r_s1_k;
    logic [D-1:0]          r_s1_delta;

    logic [ACC_W-1:0]      w_acc_rd;
    logic [ACC_W-1:0]      w_acc_nxt;
    logic [ACC_W:0]        w_sum;
    logic [ACC_W:0]        w_sum_inc;
    logic [GAMMA_STAR:0]   w_g_inc;
    logic [KW-1:0]         w_k;
    logic                  w_first;
    logic                  w_z_end;
    logic                  w_last;

    logic [D-1:0]          w_u;
    logic [DW-1:0]         w_one;
    logic [DW-1:0]         w_mask;
    logic [DW-1:0]         w_data;
    logic [CW_LEN_W-1:0]   w_len;

    // ---------------- stage 1: k search, accumulator update, indexing ----------------
    assign w_acc_rd  = r_acc[r_z];
    assign w_first   = (r_t == '0);
    assign w_z_end   = (r_z == ZW'(NZ - 1));
    assign w_last    = w_z_end && (r_t == TW'(NPIX - 1));
    assign w_sum     = {1'b0, w_acc_rd} + (ACC_W + 1)'(res);
    assign w_sum_inc = w_sum + (ACC_W + 1)'(1);
    assign w_g_inc   = {1'b0, r_g} + (GAMMA_STAR + 1)'(1);

    ccsds123_k_select #(
        .D          (D),
        .GAMMA_STAR (GAMMA_STAR),
        .ACC_W      (ACC_W),
        .KW         (KW)
    ) u_k_select (
        .i_acc (w_acc_rd),
        .i_cnt (r_g),
        .o_k   (w_k)
    );

    always_comb begin
        w_acc_nxt = ACC_INIT;
        if (!w_first) begin
            w_acc_nxt = (r_g < G_MAX) ? w_sum[ACC_W-1:0] : w_sum_inc[ACC_W:1];
        end
    end

    // Write lands at this edge; the next same-band read is a later cycle, so no bypass.
    always_ff @(posedge clk) begin
        if (aresetn && res_valid) begin
            r_acc[r_z] <= w_acc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_z        <= '0;
            r_t        <= '0;
            r_g        <= G_INIT;
            r_s1_vld   <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_k     <= '0;
            r_s1_delta <= '0;
        end else begin
            r_s1_vld <= res_valid;
            if (res_valid) begin
                r_s1_k     <= w_k;
                r_s1_delta <= res;
                r_s1_first <= w_first;
                r_s1_last  <= w_last;
                if (w_z_end) begin
                    r_z <= '0;
                    if (w_last) begin
                        r_t <= '0;
                        r_g <= G_INIT;
                    end else begin
                        r_t <= r_t + TW'(1);
                        if (!w_first) begin
                            r_g <= (r_g < G_MAX) ? w_g_inc[GAMMA_STAR-1:0] : w_g_inc[GAMMA_STAR:1];
                        end
                    end
                end else begin
                    r_z <= r_z + ZW'(1);
                end
            end
        end
    end

    // ---------------- stage 2: codeword formation ----------------
    assign w_u    = r_s1_delta >> r_s1_k;
    assign w_one  = DW'(1) << r_s1_k;
    assign w_mask = w_one - DW'(1);

    always_comb begin
        w_len  = CW_LEN_W'(D);
        w_data = DW'(r_s1_delta);
        if (!r_s1_first) begin
            if (32'(w_u) < UMAX_EFF) begin
                w_len  = CW_LEN_W'(w_u) + CW_LEN_W'(r_s1_k) + CW_LEN_W'(1);
                w_data = w_one | (DW'(r_s1_delta) & w_mask);
            end else begin
                w_len  = CW_LEN_W'(UMAX_EFF + D);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            cw_data  <= '0;
            cw_len   <= '0;
            cw_valid <= 1'b0;
            cw_last  <= 1'b0;
        end else begin
            cw_valid <= r_s1_vld;
            cw_last  <= r_s1_vld & r_s1_last;
            if (r_s1_vld) begin
                cw_data <= w_data;
                cw_len  <= w_len;
            end
        end
    end

endmodule

// File: doc/ccsds123_sa_encoder.md
Name: ccsds123_sa_encoder

Overview:
- Sample-adaptive Golomb-Power-of-2 entropy coder (CCSDS 123.0-B-1 §5.4.3.2).
- Sits directly downstream of ccsds123_top and consumes its mapped residual stream (res/res_valid, BIP order, band index fastest).
- Emits one right-aligned variable-length codeword per residual for a later bit packer.
- No backpressure: the input has no ready, so the block must accept one residual every cycle.

Parameters:
- D, 16: sample/residual bit width.
- NX, 4: image width.
- NY, 4: image height.
- NZ, 16: number of bands.
- UMAX, 18: unary length limit (8..32).
- GAMMA0, 1: initial count exponent (1..8).
- GAMMA_STAR, 6: rescaling counter size (max(4, GAMMA0+1)..9).
- KZP, 8: accumulator initialisation constant K'' (0..D-2), same for all bands.

Ports:
- clk  in  1  clock; all logic on rising edge.
- aresetn  in  1  reset, synchronous, active-low.
- res  in  D  mapped residual delta.
- res_valid  in  1  res qualifier.
- cw_data  out  UMAX+D  codeword; the first-transmitted bit is MSB of the cw_len-bit field; unused upper bits are 0.
- cw_len  out  6  codeword length in bits (1..UMAX+D).
- cw_valid  out  1  codeword qualifier.
- cw_last  out  1  high with the codeword of the final sample of an image.

Behaviour:
- Reset (aresetn=0 at an edge):
  - cw_data=0, cw_len=0, cw_valid=0, cw_last=0.
  - Band/pixel indices z=0, t=0; counter G=2^GAMMA0.
  - Accumulator RAM contents are don't-care; they are rewritten at t=0.
- Pipeline: 2 stages, latency exactly 2 cycles from res_valid to cw_valid. Bubbles propagate; throughput is 1 per cycle.
- Stage 1 (on res_valid):
  - Read accumulator A[z]; compute k with sub-module ccsds123_k_select.
  - Compute the next A[z] and register k, delta, t==0 flag and last flag.
  - Advance z; on z wrap to 0, advance t.
- t=0 (first pixel):
  - Residual is coded uncoded: cw_len=D, cw_data=delta.
  - Write A[z] = floor((3*2^(KZP+6) - 49) * 2^GAMMA0 / 2^7).
  - No G update.
- t>=1, k selection:
  - k is the largest value in 0..D-2 with G*2^k <= A[z] + floor(49*G/2^7).
  - If no value satisfies this, k=0.
- t>=1, codeword:
  - u = delta>>k.
  - If u < UMAX: u zeros, a single 1, then the k LSBs of delta. cw_len=u+1+k; cw_data=(1<<k)|(delta mod 2^k).
  - Else (escape): UMAX zeros then delta in D bits. cw_len=UMAX+D; cw_data=delta.
- Accumulator update (t>=1):
  - If G < 2^GAMMA_STAR - 1: A[z] <= A[z] + delta.
  - Else: A[z] <= floor((A[z] + delta + 1)/2).
  - Accumulator width is D+GAMMA_STAR+1; it never overflows.
- Counter G: shared by all bands, updated only when z==NZ-1 and t>=1.
  - If G < 2^GAMMA_STAR - 1: G <= G+1.
  - Else: G <= floor((G+1)/2).
- RAM hazard: A[z] is written at the end of stage 1. The next read of the same band is at least one cycle later, so it sees the new value; this holds even for NZ=1.
- End of image:
  - Sample index NX*NY*NZ-1 sets cw_last on its codeword.
  - Indices then return to z=0, t=0 and G=2^GAMMA0, so the next image starts fresh with no dead cycle.
- Reset mid-image:
  - In-flight codewords are discarded.
  - The next accepted sample is treated as t=0, z=0.

Decomposition:
- ccsds123_pkg (shared header/package) holds:
  - the codeword-length width constant (6);
  - the accumulator-width function;
  - the initial-accumulator expression as a constant function of KZP and GAMMA0;
  - the UMAX range limits.
- Sub-module ccsds123_k_select: combinational; inputs A and G; output k (priority search from D-2 down). It is reused later for the block-adaptive variant.

Test Plan:
- Uncoded first pixel: NZ residuals, delta=5 for z=0 → cw_len=16, cw_data=5 two cycles later; A[0] initialised to 767.
- Normal codeword: at t=1, z=0, delta=300 → G=2, k=8, cw_len=10, cw_data=0x12C; A[0] becomes 1067. After z=NZ-1, G=3.
- Escape: at t=1, delta=65535 → u=255>=18, cw_len=34, cw_data=0xFFFF.
- Rescale: stream about 62 pixels of delta=0 until G=63 → the next pixel end gives G=32. A[z] halves with rounding up; the tb checks this against a reference model.
- Framing and bubbles: a full 4x4x16 image with random res_valid gaps → exactly 256 codewords; cw_last only on the 256th. The second image's first pixel is uncoded again.
- Mid-image reset: assert aresetn=0 for 1 cycle after 37 samples → no cw_valid for 2 cycles. The next sample is coded uncoded (cw_len=16).
